reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 45 ++++
 rtl/reg_file.sv | 81 ++++++++
 2 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths, ready-tag convention and read-port helper for reg_file
//
// Purpose: single home for the register-index and ROB-tag widths used by the
// register file, dispatcher and ROB. A tag of 0 means "value is ready".
// Ports: none (package).

package reg_file_pkg;

   localparam int REGBW = 5;
   localparam int ROBBW = 4;
   localparam int NREG  = 1 << REGBW;

   localparam logic [ROBBW-1:0] TAG_READY = '0;

   typedef struct packed {
      logic [31:0]      v;
      logic [ROBBW-1:0] q;
   } rd_t;

   // One combinational read port. x0 always reads as ready zero. A commit in
   // the same cycle whose tag still matches the rename is forwarded, so the
   // reader never sees a tag that is retiring at this very edge.
   function automatic rd_t read_port(
      input logic [REGBW-1:0] idx,
      input logic [31:0]      v_at,
      input logic [ROBBW-1:0] q_at,
      input logic             c_flag,
      input logic [REGBW-1:0] c_rd,
      input logic [ROBBW-1:0] c_tag,
      input logic [31:0]      c_val
   );
      rd_t r;
      r.v = v_at;
      r.q = q_at;
      if (idx == '0) begin
         r.v = '0;
         r.q = TAG_READY;
      end else if (c_flag && (c_rd == idx) && (q_at == c_tag) && (q_at != TAG_READY)) begin
         r.v = c_val;
         r.q = TAG_READY;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with ROB rename tags and commit bypass
//
// Purpose: 32 x 32-bit value registers plus 32 rename tags. Two combinational
// read ports return value and producer tag (0 = ready), with forwarding of a
// same-cycle commit. Issue renames a register, commit writes its value and
// clears the tag only if no newer rename exists, flush drops every rename.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (low freezes state)
//   rs1_RF/rs2_RF -> V1_RF/Q1_RF, V2_RF/Q2_RF   read ports
//   issue_flag, issue_rd, issue_rob_id           rename on dispatch
//   commit_flag, commit_rd, commit_rob_id, commit_val   ROB-head retire
//   flush_flag                                   discard all renames

module reg_file
   import reg_file_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic [REGBW-1:0] rs1_RF,
   input  logic [REGBW-1:0] rs2_RF,
   output logic [31:0]      V1_RF,
   output logic [31:0]      V2_RF,
   output logic [ROBBW-1:0] Q1_RF,
   output logic [ROBBW-1:0] Q2_RF,
   input  logic             issue_flag,
   input  logic [REGBW-1:0] issue_rd,
   input  logic [ROBBW-1:0] issue_rob_id,
   input  logic             commit_flag,
   input  logic [REGBW-1:0] commit_rd,
   input  logic [ROBBW-1:0] commit_rob_id,
   input  logic [31:0]      commit_val,
   input  logic             flush_flag
);

   logic [31:0]      r_v [NREG];
   logic [ROBBW-1:0] r_q [NREG];

   rd_t w_rd1;
   rd_t w_rd2;

   assign w_rd1 = read_port(rs1_RF, r_v[rs1_RF], r_q[rs1_RF],
                            commit_flag, commit_rd, commit_rob_id, commit_val);
   assign w_rd2 = read_port(rs2_RF, r_v[rs2_RF], r_q[rs2_RF],
                            commit_flag, commit_rd, commit_rob_id, commit_val);

   assign V1_RF = w_rd1.v;
   assign Q1_RF = w_rd1.q;
   assign V2_RF = w_rd2.v;
   assign Q2_RF = w_rd2.q;

   logic w_commit_en;
   logic w_issue_en;

   assign w_commit_en = commit_flag && (commit_rd != '0);
   assign w_issue_en  = issue_flag && (issue_rd != '0) && !flush_flag;

   // Later assignments win: a flush overrides the commit's tag clear, and an
   // issue to the committed register keeps the newer rename.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREG; i++) begin
            r_v[i] <= '0;
            r_q[i] <= TAG_READY;
         end
      end else if (rdy_in) begin
         if (w_commit_en) begin
            r_v[commit_rd] <= commit_val;
            if (r_q[commit_rd] == commit_rob_id)
               r_q[commit_rd] <= TAG_READY;
         end
         if (flush_flag) begin
            for (int i = 0; i < NREG; i++)
               r_q[i] <= TAG_READY;
         end else if (w_issue_en) begin
            r_q[issue_rd] <= issue_rob_id;
         end
      end
   end

endmodule
